// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request port, tracks the
// next-fetch PC, and feeds a one-entry skid buffer plus the decode-side fetch register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [1:0]  i_PcSel,
  input  logic [31:0] i_PcBranch,
  input  logic [31:0] i_PcJmp,
  input  logic        i_Stall,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemReady,
  input  logic [31:0] i_IMemData,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_ProgramCounter,
  output logic [31:0] o_PcPlus4,
  output logic        o_Valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} fetchState_e;

  fetchState_e state, nextState;
  logic [31:0] fetchPc, fetchPcNext;
  logic [31:0] pendingPc, pendingPcNext;
  logic        skidValid;
  logic [31:0] skidInstr, skidPc;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        transfer;

  always_comb begin
    redirect       = (i_PcSel == 2'b01) || (i_PcSel == 2'b10);
    redirectTarget = (i_PcSel == 2'b10) ? i_PcJmp : i_PcBranch;
  end

  assign transfer  = o_IMemReq && i_IMemReady;
  assign o_PcPlus4 = o_ProgramCounter + 32'd4;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= S_IDLE;
      fetchPc   <= RESET_PC;
      pendingPc <= RESET_PC;
    end else begin
      state     <= nextState;
      fetchPc   <= fetchPcNext;
      pendingPc <= pendingPcNext;
    end
  end

  // An outstanding request cannot be withdrawn, so a redirect that arrives before
  // ready parks the target in pendingPc and lets S_DISCARD swallow the stale word.
  always_comb begin
    nextState     = state;
    fetchPcNext   = fetchPc;
    pendingPcNext = pendingPc;
    case (state)
      S_IDLE: begin
        nextState = S_FETCH;
        if (redirect) fetchPcNext = redirectTarget;
      end
      S_FETCH: begin
        if (redirect) begin
          if (o_IMemReq && !i_IMemReady) begin
            nextState     = S_DISCARD;
            pendingPcNext = redirectTarget;
          end else begin
            fetchPcNext = redirectTarget;
          end
        end else if (transfer) begin
          fetchPcNext = fetchPc + 32'd4;
        end
      end
      S_DISCARD: begin
        if (transfer) begin
          nextState   = S_FETCH;
          fetchPcNext = redirect ? redirectTarget : pendingPc;
        end else if (redirect) begin
          pendingPcNext = redirectTarget;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_IMemReq  = 1'b0;
    o_IMemAddr = fetchPc;
    case (state)
      S_FETCH:   o_IMemReq = !skidValid;
      S_DISCARD: o_IMemReq = 1'b1;
      default:   o_IMemReq = 1'b0;
    endcase
  end

  // Redirect beats stall; the skid buffer only ever holds a word fetched in S_FETCH.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      skidValid        <= 1'b0;
      skidInstr        <= NOP_INSTR;
      skidPc           <= 32'h0;
      o_Valid          <= 1'b0;
      o_Instruction    <= NOP_INSTR;
      o_ProgramCounter <= 32'h0;
    end else if (redirect) begin
      skidValid     <= 1'b0;
      o_Valid       <= 1'b0;
      o_Instruction <= NOP_INSTR;
    end else if (i_Stall) begin
      if (transfer && state == S_FETCH) begin
        skidValid <= 1'b1;
        skidInstr <= i_IMemData;
        skidPc    <= fetchPc;
      end
    end else if (skidValid) begin
      skidValid        <= 1'b0;
      o_Valid          <= 1'b1;
      o_Instruction    <= skidInstr;
      o_ProgramCounter <= skidPc;
    end else if (transfer && state == S_FETCH) begin
      o_Valid          <= 1'b1;
      o_Instruction    <= i_IMemData;
      o_ProgramCounter <= fetchPc;
    end else begin
      o_Valid       <= 1'b0;
      o_Instruction <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized run against a stream-level
// program-order model, and a second instance exercising PC wrap and mid-request reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP_A   = 32'h0000_0013;
  localparam logic [31:0] NOP_B   = 32'hCAFE_F00D;
  localparam logic [31:0] RESET_B = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst, stall, iMemReady, iMemReq, valid;
  logic [1:0]  pcSel;
  logic [31:0] pcBranch, pcJmp, iMemAddr, iMemData, instr, progCounter, pcPlus4;

  logic        rstB, readyB, reqB, validB, stallB;
  logic [1:0]  selB;
  logic [31:0] zeroWord, dataB, addrB, instrB, pcB, pcPlus4B;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP_A)) dutA (
    .i_Clk(clk), .i_Rst(rst), .i_PcSel(pcSel), .i_PcBranch(pcBranch), .i_PcJmp(pcJmp),
    .i_Stall(stall), .o_IMemReq(iMemReq), .o_IMemAddr(iMemAddr), .i_IMemReady(iMemReady),
    .i_IMemData(iMemData), .o_Instruction(instr), .o_ProgramCounter(progCounter),
    .o_PcPlus4(pcPlus4), .o_Valid(valid)
  );

  fetch_unit #(.RESET_PC(RESET_B), .NOP_INSTR(NOP_B)) dutB (
    .i_Clk(clk), .i_Rst(rstB), .i_PcSel(selB), .i_PcBranch(zeroWord), .i_PcJmp(zeroWord),
    .i_Stall(stallB), .o_IMemReq(reqB), .o_IMemAddr(addrB), .i_IMemReady(readyB),
    .i_IMemData(dataB), .o_Instruction(instrB), .o_ProgramCounter(pcB),
    .o_PcPlus4(pcPlus4B), .o_Valid(validB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  pcSel;
    logic [31:0] target;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] sel, input logic [31:0] br,
                               input logic [31:0] jmp, input logic rdy);
    rst       = 1'b0;
    stall     = s;
    pcSel     = sel;
    pcBranch  = br;
    pcJmp     = jmp;
    iMemReady = rdy;
    iMemData  = memWord(iMemAddr);
  endtask

  task automatic applyB(input logic r, input logic rdy);
    rstB   = r;
    readyB = rdy;
    dataB  = memWord(addrB);
  endtask

  initial begin
    vec_t        vecs[20];
    logic        rs, rdy, pReq, pValid, isRedirect;
    logic [1:0]  sel;
    logic [31:0] br, jmp, pAddr, pPc, pInstr, expectedPc;
    int          r;
    int          deliveries;

    rst = 1'b1; stall = 1'b0; pcSel = 2'b00; pcBranch = '0; pcJmp = '0;
    iMemReady = 1'b0; iMemData = '0;
    rstB = 1'b1; readyB = 1'b0; dataB = '0; stallB = 1'b0; selB = 2'b00; zeroWord = '0;

    vecs[0]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[1]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h000, 1'b1, 32'h000};
    vecs[2]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h004, 1'b1, 32'h004};
    vecs[3]  = '{1'b0, 2'b01, 32'h100, 1'b1, 1'b1, 32'h008, 1'b0, 32'h000};
    vecs[4]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 32'h100};
    vecs[5]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h104};
    vecs[6]  = '{1'b1, 2'b00, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
    vecs[7]  = '{1'b1, 2'b00, 32'h0,   1'b1, 1'b0, 32'h10C, 1'b1, 32'h104};
    vecs[8]  = '{1'b1, 2'b00, 32'h0,   1'b1, 1'b0, 32'h10C, 1'b1, 32'h104};
    vecs[9]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b0, 32'h10C, 1'b1, 32'h108};
    vecs[10] = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h10C};
    vecs[11] = '{1'b0, 2'b10, 32'h200, 1'b0, 1'b1, 32'h110, 1'b0, 32'h000};
    vecs[12] = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b1, 32'h110, 1'b0, 32'h000};
    vecs[13] = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b1, 32'h110, 1'b0, 32'h000};
    vecs[14] = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h110, 1'b0, 32'h000};
    vecs[15] = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 32'h200};
    vecs[16] = '{1'b1, 2'b00, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200};
    vecs[17] = '{1'b1, 2'b01, 32'h300, 1'b1, 1'b0, 32'h208, 1'b0, 32'h000};
    vecs[18] = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h300, 1'b1, 32'h300};
    vecs[19] = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h304, 1'b1, 32'h304};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReq", {31'b0, iMemReq}, 32'd0);
    checkOutput("resetValid", {31'b0, valid}, 32'd0);
    checkOutput("resetInstr", instr, NOP_A);
    checkOutput("resetPc", progCounter, 32'h0);

    // Directed table; the first row's negedge also releases reset, so it is the S_IDLE cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].stall, vecs[i].pcSel,
                    (vecs[i].pcSel == 2'b01) ? vecs[i].target : vecs[i].target ^ 32'h0000_4000,
                    (vecs[i].pcSel == 2'b10) ? vecs[i].target : vecs[i].target ^ 32'h0000_8000,
                    vecs[i].ready);
      checkOutput($sformatf("row%0d.req", i), {31'b0, iMemReq}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("row%0d.addr", i), iMemAddr, vecs[i].expAddr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d.valid", i), {31'b0, valid}, {31'b0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        checkOutput($sformatf("row%0d.pc", i), progCounter, vecs[i].expPc);
        checkOutput($sformatf("row%0d.pc4", i), pcPlus4, vecs[i].expPc + 32'd4);
        checkOutput($sformatf("row%0d.instr", i), instr, memWord(vecs[i].expPc));
      end else begin
        checkOutput($sformatf("row%0d.nop", i), instr, NOP_A);
      end
    end

    // Randomized run: delivered words must follow program order from the latest redirect.
    expectedPc = 32'h0;
    deliveries = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rs  = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 6);
      r   = $urandom_range(0, 19);
      sel = (i == 0) ? 2'b10 : (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      br  = $urandom & 32'hFFFF_FFFC;
      jmp = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rs, sel, br, jmp, rdy);
      pReq = iMemReq; pAddr = iMemAddr; pValid = valid; pPc = progCounter; pInstr = instr;
      isRedirect = (sel == 2'b01) || (sel == 2'b10);
      @(posedge clk);
      #1;
      if (pcPlus4 !== progCounter + 32'd4)
        checkOutput("rndPcPlus4", pcPlus4, progCounter + 32'd4);
      if (pReq && !rdy) begin
        checkOutput("rndReqHold", {31'b0, iMemReq}, 32'd1);
        checkOutput("rndAddrHold", iMemAddr, pAddr);
      end
      if (isRedirect) begin
        checkOutput("rndFlushValid", {31'b0, valid}, 32'd0);
        checkOutput("rndFlushInstr", instr, NOP_A);
        expectedPc = (sel == 2'b10) ? jmp : br;
      end else if (rs) begin
        checkOutput("rndStallValid", {31'b0, valid}, {31'b0, pValid});
        checkOutput("rndStallPc", progCounter, pPc);
        checkOutput("rndStallInstr", instr, pInstr);
      end else if (valid) begin
        checkOutput("rndOrderPc", progCounter, expectedPc);
        checkOutput("rndInstr", instr, memWord(progCounter));
        expectedPc = expectedPc + 32'd4;
        deliveries++;
      end else begin
        checkOutput("rndBubbleInstr", instr, NOP_A);
      end
    end
    checkOutput("rndProgress", {31'b0, deliveries >= 200}, 32'd1);

    // Second instance: wrap from 0xFFFF_FFFC and reset abandoning a waiting request.
    @(negedge clk);
    checkOutput("bResetReq", {31'b0, reqB}, 32'd0);
    checkOutput("bResetInstr", instrB, NOP_B);
    checkOutput("bResetPc", pcB, 32'h0);
    applyB(1'b0, 1'b1);
    checkOutput("bIdleReq", {31'b0, reqB}, 32'd0);
    @(negedge clk);
    applyB(1'b0, 1'b1);
    checkOutput("bReq0", {31'b0, reqB}, 32'd1);
    checkOutput("bAddr0", addrB, RESET_B);
    @(posedge clk);
    #1;
    checkOutput("bValid0", {31'b0, validB}, 32'd1);
    checkOutput("bPc0", pcB, RESET_B);
    checkOutput("bPcPlus4Wrap", pcPlus4B, 32'h0);
    checkOutput("bInstr0", instrB, memWord(RESET_B));
    @(negedge clk);
    applyB(1'b0, 1'b1);
    checkOutput("bAddrWrap", addrB, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("bPc1", pcB, 32'h0);
    @(negedge clk);
    applyB(1'b0, 1'b1);
    checkOutput("bAddr2", addrB, 32'h4);
    @(posedge clk);
    #1;
    checkOutput("bPc2", pcB, 32'h4);
    @(negedge clk);
    applyB(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bWaitReq", {31'b0, reqB}, 32'd1);
    checkOutput("bWaitAddr", addrB, 32'h8);
    applyB(1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bAbortReq", {31'b0, reqB}, 32'd0);
    checkOutput("bAbortValid", {31'b0, validB}, 32'd0);
    checkOutput("bAbortInstr", instrB, NOP_B);
    @(negedge clk);
    applyB(1'b0, 1'b1);
    checkOutput("bIdleReq2", {31'b0, reqB}, 32'd0);
    @(negedge clk);
    applyB(1'b0, 1'b1);
    checkOutput("bRestartReq", {31'b0, reqB}, 32'd1);
    checkOutput("bRestartAddr", addrB, RESET_B);
    @(posedge clk);
    #1;
    checkOutput("bRestartPc", pcB, RESET_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
